// File: rtl/apb_uart_csr_pkg.sv
// Shared register offsets, state encoding and decoded register selects for the UART CSR slave.
package apb_uart_csr_pkg;

  localparam int unsigned CTRL_OFS   = 'h000;
  localparam int unsigned BAUD_OFS   = 'h004;
  localparam int unsigned STATUS_OFS = 'h008;
  localparam int unsigned TXD_OFS    = 'h00C;
  localparam int unsigned RXD_OFS    = 'h010;

  localparam logic [15:0] BAUD_RST_DEF = 16'h0036;

  typedef enum logic {IDLE, ACCESS} state_e;

  typedef enum logic [2:0] {
    REG_CTRL, REG_BAUD, REG_STATUS, REG_TXD, REG_RXD, REG_NONE
  } reg_e;

endpackage

// File: rtl/apb_uart_csr_decode.sv
// Combinational address/direction decode: register select plus an error flag for
// unaligned, unmapped or write-to-read-only accesses. Zero latency, no flow control.
module apb_uart_csr_decode
  import apb_uart_csr_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  output reg_e              sel,
  output logic              err
);

  always_comb begin
    sel = REG_NONE;
    err = 1'b0;
    if (addr[1:0] != 2'b00)                 err = 1'b1;
    else if (addr == ADDR_W'(CTRL_OFS))     sel = REG_CTRL;
    else if (addr == ADDR_W'(BAUD_OFS))     sel = REG_BAUD;
    else if (addr == ADDR_W'(STATUS_OFS))   sel = REG_STATUS;
    else if (addr == ADDR_W'(TXD_OFS))      sel = REG_TXD;
    else if (addr == ADDR_W'(RXD_OFS))      sel = REG_RXD;
    else                                    err = 1'b1;
    if (write && (sel == REG_STATUS || sel == REG_RXD)) err = 1'b1;
  end

endmodule

// File: rtl/apb_uart_csr_slave.sv
// APB completer for the UART CSR bank; access phase is WAIT_STATES+1 cycles, then pready
// is held until the master completes or drops psel. TX/RX side effects pulse after completion.
module apb_uart_csr_slave
  import apb_uart_csr_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] BAUD_RST    = BAUD_RST_DEF,
  parameter int          ADDR_W      = 12
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [3:0]        pstrb,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [31:0]       ctrl_o,
  output logic [15:0]       baud_div_o,
  input  logic [7:0]        status_i,
  input  logic              tx_full_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_push_o,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_pop_o
);

  state_e      state;
  logic [3:0]  cnt;
  reg_e        a_sel;
  logic        a_write;
  logic        a_err;
  logic [3:0]  a_strb;
  logic [31:0] a_wdata;

  reg_e        dec_sel;
  logic        dec_err;

  apb_uart_csr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr  (paddr),
    .write (pwrite),
    .sel   (dec_sel),
    .err   (dec_err)
  );

  // With zero wait states the response is formed from the live setup decode.
  reg_e        r_sel;
  logic        r_write;
  logic        rsp_err;
  logic [31:0] rsp_data;

  always_comb begin
    r_sel    = (state == IDLE) ? dec_sel : a_sel;
    r_write  = (state == IDLE) ? pwrite  : a_write;
    rsp_err  = ((state == IDLE) ? dec_err : a_err)
             | (r_write  && r_sel == REG_TXD && tx_full_i)
             | (!r_write && r_sel == REG_RXD && !rx_valid_i);
    rsp_data = 32'h0;
    if (!r_write && !rsp_err) begin
      case (r_sel)
        REG_CTRL:   rsp_data = ctrl_o;
        REG_BAUD:   rsp_data = {16'h0, baud_div_o};
        REG_STATUS: rsp_data = {24'h0, status_i};
        REG_RXD:    rsp_data = {24'h0, rx_data_i};
        default:    rsp_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      a_sel      <= REG_NONE;
      a_write    <= 1'b0;
      a_err      <= 1'b0;
      a_strb     <= 4'h0;
      a_wdata    <= 32'h0;
      prdata     <= 32'h0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      ctrl_o     <= 32'h0;
      baud_div_o <= BAUD_RST;
      tx_data_o  <= 8'h0;
      tx_push_o  <= 1'b0;
      rx_pop_o   <= 1'b0;
    end else begin
      tx_push_o <= 1'b0;
      rx_pop_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state   <= ACCESS;
            cnt     <= 4'(WAIT_STATES);
            a_sel   <= dec_sel;
            a_write <= pwrite;
            a_err   <= dec_err;
            a_strb  <= pstrb;
            a_wdata <= pwdata;
            if (WAIT_STATES == 0) begin
              pready  <= 1'b1;
              pslverr <= rsp_err;
              prdata  <= rsp_data;
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 32'h0;
          end else if (pready && penable) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 32'h0;
            // Commit follows the response already returned to the master.
            if (!pslverr) begin
              if (a_write) begin
                case (a_sel)
                  REG_CTRL: begin
                    for (int b = 0; b < 4; b++)
                      if (a_strb[b]) ctrl_o[8*b +: 8] <= a_wdata[8*b +: 8];
                  end
                  REG_BAUD: begin
                    for (int b = 0; b < 2; b++)
                      if (a_strb[b]) baud_div_o[8*b +: 8] <= a_wdata[8*b +: 8];
                  end
                  REG_TXD: begin
                    if (a_strb[0]) begin
                      tx_data_o <= a_wdata[7:0];
                      tx_push_o <= 1'b1;
                    end
                  end
                  default: ;
                endcase
              end else if (a_sel == REG_RXD) begin
                rx_pop_o <= 1'b1;
              end
            end
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              pready  <= 1'b1;
              pslverr <= rsp_err;
              prdata  <= rsp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
